// File: rtl/fetch_unit.sv
// Fetch engine: issues packet-aligned fetch requests under a credit limit,
// collects in-order responses into a small queue for the instruction buffer,
// and drops responses that were in flight when a redirect arrived.
module fetch_unit #(
    parameter int unsigned              CPU_ADDR_BITS = 32,
    parameter int unsigned              CPU_INST_BITS = 32,
    parameter int unsigned              FETCH_WIDTH   = 2,
    parameter logic [CPU_ADDR_BITS-1:0] RESET_PC      = '0,
    parameter int unsigned              RESP_Q_DEPTH  = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush,
    input  logic [CPU_ADDR_BITS-1:0]             redirect_pc,
    output logic                                 imem_req_val,
    input  logic                                 imem_req_rdy,
    output logic [CPU_ADDR_BITS-1:0]             imem_req_addr,
    input  logic                                 imem_resp_val,
    input  logic [FETCH_WIDTH*CPU_INST_BITS-1:0] imem_resp_data,
    output logic [CPU_ADDR_BITS-1:0]             pc,
    output logic [FETCH_WIDTH*CPU_INST_BITS-1:0] icache_dout,
    output logic                                 icache_dout_val,
    input  logic                                 inst_buffer_rdy
);

    localparam int unsigned PktBits  = FETCH_WIDTH * CPU_INST_BITS;
    localparam int unsigned PktBytes = PktBits / 8;
    localparam int unsigned PtrBits  = $clog2(RESP_Q_DEPTH);
    localparam int unsigned CntBits  = $clog2(RESP_Q_DEPTH + 1);

    localparam logic [CPU_ADDR_BITS-1:0] PcStride = CPU_ADDR_BITS'(PktBytes);
    localparam logic [CPU_ADDR_BITS-1:0] OffMask  = CPU_ADDR_BITS'(PktBytes - 1);
    localparam logic [CntBits:0]         QDepth   = (CntBits + 1)'(RESP_Q_DEPTH);

    // Architectural state
    logic [CPU_ADDR_BITS-1:0] r_fetch_pc, w_fetch_pc_d;
    logic [CntBits-1:0]       r_inflight, w_inflight_d;
    logic [CntBits-1:0]       r_drop_cnt, w_drop_cnt_d;
    logic [CntBits-1:0]       r_q_cnt,    w_q_cnt_d;
    logic [PtrBits-1:0]       r_q_wptr,   w_q_wptr_d;
    logic [PtrBits-1:0]       r_q_rptr,   w_q_rptr_d;
    logic [PtrBits-1:0]       r_pf_wptr,  w_pf_wptr_d;
    logic [PtrBits-1:0]       r_pf_rptr,  w_pf_rptr_d;

    // Storage: response queue {pc, data} and issued-address FIFO
    logic [CPU_ADDR_BITS-1:0] r_q_pc   [RESP_Q_DEPTH];
    logic [PktBits-1:0]       r_q_data [RESP_Q_DEPTH];
    logic [CPU_ADDR_BITS-1:0] r_pf_pc  [RESP_Q_DEPTH];

    logic w_credit_ok;
    logic w_fire;
    logic w_drop;
    logic w_enq;
    logic w_deq;

    // Issue gating and handshake decode
    always_comb begin
        // A slot is reserved for every outstanding request, so responses never stall.
        w_credit_ok     = ({1'b0, r_inflight} + {1'b0, r_q_cnt}) < QDepth;
        imem_req_val    = ~rst & ~flush & w_credit_ok;
        imem_req_addr   = r_fetch_pc;
        w_fire          = imem_req_val & imem_req_rdy;
        w_drop          = imem_resp_val & (r_drop_cnt != '0);
        w_enq           = imem_resp_val & ~w_drop & ~flush;
        icache_dout_val = (r_q_cnt != '0);
        w_deq           = icache_dout_val & inst_buffer_rdy;
        pc              = r_q_pc[r_q_rptr];
        icache_dout     = r_q_data[r_q_rptr];
    end

    // Next-state for counters, pointers and fetch PC
    always_comb begin
        w_inflight_d = r_inflight;
        if (w_fire && !imem_resp_val) begin
            w_inflight_d = r_inflight + CntBits'(1);
        end else if (!w_fire && imem_resp_val) begin
            w_inflight_d = r_inflight - CntBits'(1);
        end

        w_pf_wptr_d = w_fire        ? r_pf_wptr + PtrBits'(1) : r_pf_wptr;
        w_pf_rptr_d = imem_resp_val ? r_pf_rptr + PtrBits'(1) : r_pf_rptr;

        w_fetch_pc_d = w_fire ? r_fetch_pc + PcStride : r_fetch_pc;
        w_drop_cnt_d = w_drop ? r_drop_cnt - CntBits'(1) : r_drop_cnt;
        w_q_wptr_d   = w_enq ? r_q_wptr + PtrBits'(1) : r_q_wptr;
        w_q_rptr_d   = w_deq ? r_q_rptr + PtrBits'(1) : r_q_rptr;
        w_q_cnt_d    = r_q_cnt;
        if (w_enq && !w_deq) begin
            w_q_cnt_d = r_q_cnt + CntBits'(1);
        end else if (!w_enq && w_deq) begin
            w_q_cnt_d = r_q_cnt - CntBits'(1);
        end

        // Redirect wins: everything still outstanding after this edge is stale.
        if (flush) begin
            w_fetch_pc_d = redirect_pc & ~OffMask;
            w_drop_cnt_d = w_inflight_d;
            w_q_cnt_d    = '0;
            w_q_wptr_d   = '0;
            w_q_rptr_d   = '0;
        end
    end

    // Control state register with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_inflight <= '0;
            r_drop_cnt <= '0;
            r_q_cnt    <= '0;
            r_q_wptr   <= '0;
            r_q_rptr   <= '0;
            r_pf_wptr  <= '0;
            r_pf_rptr  <= '0;
        end else begin
            r_fetch_pc <= w_fetch_pc_d;
            r_inflight <= w_inflight_d;
            r_drop_cnt <= w_drop_cnt_d;
            r_q_cnt    <= w_q_cnt_d;
            r_q_wptr   <= w_q_wptr_d;
            r_q_rptr   <= w_q_rptr_d;
            r_pf_wptr  <= w_pf_wptr_d;
            r_pf_rptr  <= w_pf_rptr_d;
        end
    end

    // Payload storage; contents are qualified by the counters so need no reset
    always_ff @(posedge clk) begin
        if (w_fire) begin
            r_pf_pc[r_pf_wptr] <= r_fetch_pc;
        end
        if (w_enq) begin
            r_q_pc[r_q_wptr]   <= r_pf_pc[r_pf_rptr];
            r_q_data[r_q_wptr] <= imem_resp_data;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a 1-cycle memory model (with a hold control),
// expected request/output queues filled by the stimulus, and a monitor that
// pops and compares whenever the DUT fires a request or delivers a packet.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        imem_req_val;
    logic        imem_req_rdy;
    logic [31:0] imem_req_addr;
    logic        imem_resp_val;
    logic [63:0] imem_resp_data;
    logic [31:0] pc;
    logic [63:0] icache_dout;
    logic        icache_dout_val;
    logic        inst_buffer_rdy;

    logic        mem_hold;
    logic [31:0] exp_req[$];
    logic [31:0] exp_out[$];
    logic [31:0] pend[$];
    int          n_cmp;
    int          n_err;
    int          n_fire;

    fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .redirect_pc     (redirect_pc),
        .imem_req_val    (imem_req_val),
        .imem_req_rdy    (imem_req_rdy),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_val   (imem_resp_val),
        .imem_resp_data  (imem_resp_data),
        .pc              (pc),
        .icache_dout     (icache_dout),
        .icache_dout_val (icache_dout_val),
        .inst_buffer_rdy (inst_buffer_rdy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] pkt_of(input logic [31:0] a);
        return {a ^ 32'hDEAD_BEEF, a};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Memory: answers each accepted request one cycle later, in order.
    initial begin
        imem_resp_val  = 1'b0;
        imem_resp_data = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!mem_hold && pend.size() > 0) begin
                logic [31:0] a;
                a              = pend.pop_front();
                imem_resp_val  = 1'b1;
                imem_resp_data = pkt_of(a);
            end else begin
                imem_resp_val  = 1'b0;
            end
            #1;
            if (!rst && imem_req_val && imem_req_rdy) pend.push_back(imem_req_addr);
        end
    end

    // Monitor: compares requests and delivered packets against expected queues.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (!rst) begin
                if (imem_req_val) begin
                    if (exp_req.size() > 0) begin
                        check("req_addr", {32'h0, imem_req_addr}, {32'h0, exp_req[0]});
                        if (imem_req_rdy) void'(exp_req.pop_front());
                    end else if (imem_req_rdy) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL req_unexpected: got addr %h expected no request",
                                 imem_req_addr);
                    end
                    if (imem_req_rdy) n_fire++;
                end
                if (icache_dout_val && inst_buffer_rdy) begin
                    if (exp_out.size() > 0) begin
                        logic [31:0] e;
                        e = exp_out.pop_front();
                        check("out_pc", {32'h0, pc}, {32'h0, e});
                        check("out_data", icache_dout, pkt_of(e));
                    end else begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL out_unexpected: got pc %h expected no packet", pc);
                    end
                end
            end
        end
    end

    task automatic run_until_fires(input int k);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (n_fire >= k) begin
                imem_req_rdy = 1'b0;
                return;
            end
        end
        imem_req_rdy = 1'b0;
        n_cmp++;
        n_err++;
        $display("FAIL fire_timeout: got %0d fires expected %0d", n_fire, k);
    endtask

    task automatic drain();
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (exp_out.size() == 0 && exp_req.size() == 0) return;
        end
        n_cmp++;
        n_err++;
        $display("FAIL drain_timeout: got %0d outs %0d reqs pending expected 0",
                 exp_out.size(), exp_req.size());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp           = 0;
        n_err           = 0;
        n_fire          = 0;
        rst             = 1'b1;
        flush           = 1'b0;
        redirect_pc     = '0;
        imem_req_rdy    = 1'b1;
        inst_buffer_rdy = 1'b1;
        mem_hold        = 1'b0;

        // Reset: no request, no output even with rdy high
        repeat (3) begin
            @(negedge clk);
            #3;
            check("rst_req_val", {63'h0, imem_req_val}, 64'h0);
            check("rst_dout_val", {63'h0, icache_dout_val}, 64'h0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Streaming from RESET_PC
        for (int i = 0; i < 8; i++) begin
            exp_req.push_back(32'(i * 8));
            exp_out.push_back(32'(i * 8));
        end
        run_until_fires(8);
        drain();

        // Buffer back-pressure: only two requests fit
        inst_buffer_rdy = 1'b0;
        imem_req_rdy    = 1'b1;
        exp_req.push_back(32'h40);
        exp_req.push_back(32'h48);
        repeat (6) @(negedge clk);
        #3;
        check("bp_fires", 64'(n_fire), 64'd10);
        check("bp_req_val", {63'h0, imem_req_val}, 64'h0);
        check("bp_dout_val", {63'h0, icache_dout_val}, 64'h1);
        check("bp_head_pc", {32'h0, pc}, 64'h40);
        check("bp_head_data", icache_dout, pkt_of(32'h40));
        @(negedge clk);
        exp_out.push_back(32'h40);
        exp_out.push_back(32'h48);
        exp_req.push_back(32'h50);
        exp_req.push_back(32'h58);
        exp_out.push_back(32'h50);
        exp_out.push_back(32'h58);
        inst_buffer_rdy = 1'b1;
        run_until_fires(12);
        drain();

        // Flush with two requests in flight: both responses dropped
        mem_hold     = 1'b1;
        imem_req_rdy = 1'b1;
        exp_req.push_back(32'h60);
        exp_req.push_back(32'h68);
        run_until_fires(14);
        flush       = 1'b1;
        redirect_pc = 32'h1004;
        exp_req.push_back(32'h1000);
        exp_req.push_back(32'h1008);
        exp_out.push_back(32'h1000);
        exp_out.push_back(32'h1008);
        #3;
        check("flush1_req_val", {63'h0, imem_req_val}, 64'h0);
        @(negedge clk);
        flush        = 1'b0;
        mem_hold     = 1'b0;
        imem_req_rdy = 1'b1;
        run_until_fires(16);
        drain();

        // Flush coinciding with a response while drop_cnt is zero
        mem_hold     = 1'b1;
        imem_req_rdy = 1'b1;
        exp_req.push_back(32'h1010);
        exp_req.push_back(32'h1018);
        run_until_fires(18);
        mem_hold    = 1'b0;
        flush       = 1'b1;
        redirect_pc = 32'h2000;
        exp_req.push_back(32'h2000);
        exp_req.push_back(32'h2008);
        exp_out.push_back(32'h2000);
        exp_out.push_back(32'h2008);
        @(negedge clk);
        flush        = 1'b0;
        imem_req_rdy = 1'b1;
        #3;
        check("flush2_next_val", {63'h0, imem_req_val}, 64'h1);
        check("flush2_next_addr", {32'h0, imem_req_addr}, 64'h2000);
        run_until_fires(20);
        drain();

        // Idle flush to an unaligned target near the top: alignment, latency, wrap
        flush        = 1'b1;
        redirect_pc  = 32'hFFFF_FFFB;
        imem_req_rdy = 1'b1;
        exp_req.push_back(32'hFFFF_FFF8);
        exp_req.push_back(32'h0);
        exp_req.push_back(32'h8);
        exp_out.push_back(32'hFFFF_FFF8);
        exp_out.push_back(32'h0);
        exp_out.push_back(32'h8);
        #3;
        check("flush3_req_val", {63'h0, imem_req_val}, 64'h0);
        @(negedge clk);
        flush = 1'b0;
        #3;
        check("wrap_first_addr", {32'h0, imem_req_addr}, 64'hFFFF_FFF8);
        @(negedge clk);
        #3;
        check("lat_resp_cycle_dout_val", {63'h0, icache_dout_val}, 64'h0);
        @(negedge clk);
        #3;
        check("lat_next_dout_val", {63'h0, icache_dout_val}, 64'h1);
        check("lat_next_pc", {32'h0, pc}, 64'hFFFF_FFF8);
        run_until_fires(23);
        drain();

        // Request-ready toggling 1,0,1: address held, no duplicates or skips
        exp_req.push_back(32'h10);
        exp_req.push_back(32'h18);
        exp_req.push_back(32'h20);
        exp_out.push_back(32'h10);
        exp_out.push_back(32'h18);
        exp_out.push_back(32'h20);
        begin
            int i;
            i = 0;
            while (n_fire < 26 && i < 60) begin
                imem_req_rdy = (i % 3 != 1);
                i++;
                @(negedge clk);
            end
            imem_req_rdy = 1'b0;
            if (n_fire < 26) begin
                n_cmp++;
                n_err++;
                $display("FAIL toggle_timeout: got %0d fires expected 26", n_fire);
            end
        end
        drain();

        repeat (3) @(negedge clk);
        #3;
        check("end_dout_val", {63'h0, icache_dout_val}, 64'h0);
        check("end_fires", 64'(n_fire), 64'd26);
        check("end_exp_out_left", 64'(exp_out.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
